// File: rtl/ila_link_pkg.sv
// ila_link_pkg
// Definitions shared by the transmit and receive halves of the ILA host link.
//   - FSM state encoding for the command-nibble serialiser.
//   - Layout of a link byte: header pattern in the upper nibble, and either a
//     count or a payload nibble in the lower nibble.
//   - link_byte(): assembles a byte from the two nibbles using that layout.
package ila_link_pkg;

  // Serialiser states
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HDR  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  // Link byte layout: [7:4] header pattern, [3:0] count or payload nibble
  localparam int HDR_ADDR_MSB = 7;
  localparam int HDR_ADDR_LSB = 4;
  localparam int HDR_LOW_MSB  = 3;
  localparam int HDR_LOW_LSB  = 0;

  // Build a link byte from its header pattern and low nibble
  function automatic logic [7:0] link_byte(input logic [3:0] hi, input logic [3:0] lo);
    logic [7:0] b;
    b = 8'h00;
    b[HDR_ADDR_MSB:HDR_ADDR_LSB] = hi;
    b[HDR_LOW_MSB:HDR_LOW_LSB]   = lo;
    return b;
  endfunction

endpackage

// File: rtl/tx_cmd_nib.sv
// tx_cmd_nib
// Serialises one NIBBLES-wide word into link bytes for the host transmitter.
// A word goes out as one header byte {ADDR, NIBBLES-1} followed by NIBBLES
// data bytes {ADDR, nibble}, most significant nibble first.
// Ports:
//   i_clk         system clock, all logic on the rising edge
//   i_rst_n       synchronous active-low reset
//   i_start       send request, sampled only while idle
//   i_data        word to send, captured together with an accepted i_start
//   i_abort       cancel the word in flight (ignored while idle)
//   o_byte        byte offered to the downstream transmitter
//   o_byte_valid  o_byte holds a valid byte
//   i_byte_ready  downstream accepts o_byte this cycle
//   o_busy        a word is being sent (header or data phase)
//   o_done        one-cycle pulse after the last data byte is accepted
module tx_cmd_nib
  import ila_link_pkg::*;
#(
  parameter logic [3:0] ADDR    = 4'b0000,
  parameter int         NIBBLES = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [4*NIBBLES-1:0] i_data,
  input  logic                 i_abort,
  output logic [7:0]           o_byte,
  output logic                 o_byte_valid,
  input  logic                 i_byte_ready,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int         W        = 4 * NIBBLES;
  localparam logic [3:0] CNT_LOAD = 4'(NIBBLES - 1);

  // The 4-bit count field limits a word to 16 nibbles
  if ((NIBBLES < 1) || (NIBBLES > 16)) begin : g_bad_nibbles
    $fatal(1, "tx_cmd_nib: NIBBLES must be within 1..16");
  end

  logic [1:0]   state_r, state_s;
  logic [W-1:0] shreg_r, shreg_s;
  logic [3:0]   cnt_r, cnt_s;
  logic [7:0]   byte_r, byte_s;
  logic         valid_r, valid_s;
  logic         busy_r, busy_s;
  logic         done_r, done_s;
  logic         xfer_s;
  logic [W-1:0] shifted_s;

  // Handshake and the look-ahead of the next data nibble
  always_comb begin
    xfer_s    = valid_r & i_byte_ready;
    shifted_s = shreg_r << 4'd4;
  end

  // Next-state logic; outputs are computed one cycle early so they leave on flops
  always_comb begin
    state_s = state_r;
    shreg_s = shreg_r;
    cnt_s   = cnt_r;
    byte_s  = byte_r;
    valid_s = valid_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        // i_abort is deliberately not looked at here
        if (i_start) begin
          state_s = HDR;
          shreg_s = i_data;
          cnt_s   = CNT_LOAD;
          byte_s  = link_byte(ADDR, CNT_LOAD);
          valid_s = 1'b1;
          busy_s  = 1'b1;
        end else begin
          state_s = IDLE;
          byte_s  = 8'h00;
          valid_s = 1'b0;
          busy_s  = 1'b0;
        end
      end
      HDR: begin
        // Abort wins over a transfer in the same cycle
        if (i_abort) begin
          state_s = IDLE;
          byte_s  = 8'h00;
          valid_s = 1'b0;
          busy_s  = 1'b0;
        end else if (xfer_s) begin
          state_s = DATA;
          byte_s  = link_byte(ADDR, shreg_r[W-1 -: 4]);
        end else begin
          state_s = HDR;
        end
      end
      DATA: begin
        if (i_abort) begin
          state_s = IDLE;
          byte_s  = 8'h00;
          valid_s = 1'b0;
          busy_s  = 1'b0;
        end else if (xfer_s) begin
          if (cnt_r == 4'd0) begin
            state_s = IDLE;
            byte_s  = 8'h00;
            valid_s = 1'b0;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            state_s = DATA;
            shreg_s = shifted_s;
            cnt_s   = cnt_r - 4'd1;
            byte_s  = link_byte(ADDR, shifted_s[W-1 -: 4]);
          end
        end else begin
          state_s = DATA;
        end
      end
      default: begin
        state_s = IDLE;
        byte_s  = 8'h00;
        valid_s = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
      shreg_r <= '0;
      cnt_r   <= 4'd0;
      byte_r  <= 8'h00;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      shreg_r <= shreg_s;
      cnt_r   <= cnt_s;
      byte_r  <= byte_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign o_byte       = byte_r;
  assign o_byte_valid = valid_r;
  assign o_busy       = busy_r;
  assign o_done       = done_r;

endmodule

// File: doc/tx_cmd_nib.md
Name: tx_cmd_nib

Overview:
- Transmit-side counterpart of the ILA command-nibble receiver.
- Serialises one NIBBLES-wide data word into a byte stream for the host link (UART/SPI byte transmitter).
- Every byte carries the ADDR pattern in its upper nibble and a payload nibble in its lower nibble.
- The host matches the upper nibble and extracts the lower nibble, exactly as the FPGA-side receiver does.

Parameters:
- ADDR, 4'b0000, header pattern placed in bits [7:4] of every emitted byte.
- NIBBLES, 8, number of payload nibbles per word; legal range 1..16.

Ports:
- i_clk  input  1  system clock; all logic on posedge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_start  input  1  request to send i_data; sampled only in IDLE.
- i_data  input  4*NIBBLES  word to send; captured on the accepted i_start edge.
- i_abort  input  1  cancel the transfer in progress.
- o_byte  output  8  byte to downstream transmitter.
- o_byte_valid  output  1  o_byte holds a valid byte.
- i_byte_ready  input  1  downstream accepts o_byte this cycle.
- o_busy  output  1  transfer in progress (HDR or DATA state).
- o_done  output  1  one-cycle pulse after the last data byte is accepted.

Behaviour:
- Reset (i_rst_n=0 at an edge): state=IDLE; o_byte=8'h00, o_byte_valid=0, o_busy=0, o_done=0; shift register and counter cleared. Applies mid-transfer: no further bytes, no o_done.
- Handshake: a byte transfers at an edge where o_byte_valid&i_byte_ready=1. While valid&&!ready, o_byte is held stable. Valid never deasserts without a transfer, except on abort or reset.
- IDLE: o_byte_valid=0, o_busy=0. If i_start=1, latch i_data into the shift register, load cnt=NIBBLES-1, go to HDR.
- Start latency: first valid byte appears the cycle after i_start is sampled.
- HDR: o_byte={ADDR, 4'(NIBBLES-1)}, valid=1, busy=1. On transfer go to DATA.
- DATA: o_byte={ADDR, shreg[4*NIBBLES-1 -: 4]} (MSB nibble first), valid=1, busy=1.
  - On transfer with cnt!=0: shift left by 4, decrement cnt.
  - On transfer with cnt==0: go to IDLE and set o_done=1 for exactly the next cycle.
- Byte count: NIBBLES+1 bytes per word. Throughput is 1 byte/cycle when ready is held high.
- o_done cycle: state is already IDLE and o_busy=0. An i_start in that same cycle is accepted, giving back-to-back words.
- i_start while busy: ignored; it is neither queued nor allowed to corrupt the shift register.
- i_abort=1 in HDR/DATA: next cycle IDLE, valid=0, busy=0, no o_done. Abort takes precedence over a simultaneous transfer. i_abort in IDLE has no effect, even if i_start is high in the same cycle.
- Counter is 4 bits wide. NIBBLES=1 sends header {ADDR,4'h0} followed by one data byte.
- Elaboration: NIBBLES outside 1..16 is a fatal error (generate-time check).

Decomposition:
- Shared package ila_link_pkg holds:
  - state encoding localparams: IDLE=2'd0, HDR=2'd1, DATA=2'd2;
  - the header-byte layout constants (ADDR in [7:4], count or payload in [3:0]) shared with the receiver.
- No sub-module: a single FSM plus shift register and counter in one module.

Test Plan:
1. ADDR=4'hA, NIBBLES=4, i_data=16'h1234, ready held 1 -> bytes 8'hA3, 8'hA1, 8'hA2, 8'hA3, 8'hA4 on 5 consecutive cycles; o_done pulses one cycle after the A4 transfer; o_busy high for exactly 5 cycles.
2. Same word, ready toggled 1,0,0,1,... -> o_byte held constant through each stall; sequence identical to scenario 1; no byte duplicated or dropped.
3. i_start during DATA with i_data=16'hFFFF -> ignored; the in-flight word 16'h1234 is emitted unchanged; exactly one o_done pulse.
4. i_abort asserted while the byte 8'hA2 is valid and ready=1 -> that transfer does not count; valid=0 and busy=0 next cycle; no o_done; next i_start with 16'h5678 emits 8'hA3, 8'hA5, ..., 8'hA8 cleanly.
5. i_rst_n=0 for one cycle mid-DATA -> all outputs 0 at the next edge; state IDLE; i_start afterwards begins a fresh header.
6. i_start asserted in the o_done cycle with 16'hBEEF -> next cycle o_byte=8'hA3 valid; bytes A3, AB, AE, AE, AF follow with no idle gap.
